// File: rtl/bram_sync_dp_be.sv
// True-dual-port single-clock block RAM with per-byte write enables,
// selectable same-port read-during-write behaviour, optional output register
// and a built-in engine that fills the whole array with CLEAR_VAL.
module bram_sync_dp_be #(
   parameter int                          RAM_DATA_WIDTH = 32,
   parameter int                          RAM_ADDR_WIDTH = 4,
   parameter int                          BYTE_WIDTH     = 8,
   parameter int                          RD_MODE        = 0,
   parameter int                          OUT_REG        = 0,
   parameter logic [RAM_DATA_WIDTH-1:0]   CLEAR_VAL      = '0,
   localparam int                         NB             = RAM_DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      a_en,
   input  logic                      a_wr,
   input  logic [NB-1:0]             a_be,
   input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
   input  logic [RAM_DATA_WIDTH-1:0] a_data_in,
   output logic [RAM_DATA_WIDTH-1:0] a_data_out,
   output logic                      a_valid,
   input  logic                      b_en,
   input  logic                      b_wr,
   input  logic [NB-1:0]             b_be,
   input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
   input  logic [RAM_DATA_WIDTH-1:0] b_data_in,
   output logic [RAM_DATA_WIDTH-1:0] b_data_out,
   output logic                      b_valid,
   input  logic                      clr_start,
   output logic                      busy,
   output logic                      collision
);

   localparam int                    DEPTH   = 2 ** RAM_ADDR_WIDTH;
   localparam logic [RAM_ADDR_WIDTH:0] CNT_END = (RAM_ADDR_WIDTH+1)'(DEPTH);
   localparam logic [RAM_ADDR_WIDTH:0] CNT_ONE = (RAM_ADDR_WIDTH+1)'(1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                    state_q, state_d;
   logic [RAM_ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

   logic                      a_acc, b_acc, a_we, b_we, same_addr;
   logic [RAM_DATA_WIDTH-1:0] a_old, b_old, a_wword, b_wword;
   logic [RAM_DATA_WIDTH-1:0] a_rdata, b_rdata;
   logic                      a_rv, b_rv;

   logic [RAM_DATA_WIDTH-1:0] a_d1_q, b_d1_q;
   logic                      a_v1_q, b_v1_q, coll_q;

   // Overlay the enabled byte lanes of wdata onto base.
   function automatic logic [RAM_DATA_WIDTH-1:0] lane_merge(
      input logic [RAM_DATA_WIDTH-1:0] base,
      input logic [RAM_DATA_WIDTH-1:0] wdata,
      input logic [NB-1:0]             be);
      logic [RAM_DATA_WIDTH-1:0] r;
      r = base;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return r;
   endfunction

   assign busy      = (state_q == S_CLEAR);
   // Accesses are dropped while clearing and while reset is held.
   assign a_acc     = a_en & ~busy & rst;
   assign b_acc     = b_en & ~busy & rst;
   assign a_we      = a_acc & a_wr;
   assign b_we      = b_acc & b_wr;
   assign same_addr = (a_addr == b_addr);
   assign a_old     = mem[a_addr];
   assign b_old     = mem[b_addr];

   // Final stored word per port; on a shared address both ports compute the
   // same word, with port A overriding port B on common lanes.
   assign a_wword = lane_merge(lane_merge(a_old, b_data_in, (b_we & same_addr) ? b_be : '0),
                               a_data_in, a_be);
   assign b_wword = lane_merge(lane_merge(b_old, b_data_in, b_be),
                               a_data_in, (a_we & same_addr) ? a_be : '0);

   // Same-port read-during-write selection; a cross-port reader always sees the old word.
   assign a_rv    = a_acc & ~(a_wr & (RD_MODE == 2));
   assign b_rv    = b_acc & ~(b_wr & (RD_MODE == 2));
   assign a_rdata = (a_wr && RD_MODE == 1) ? a_wword : a_old;
   assign b_rdata = (b_wr && RD_MODE == 1) ? b_wword : b_old;

   // Memory array: clear-engine writes and port writes (never concurrent).
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) mem[cnt_q[RAM_ADDR_WIDTH-1:0]] <= CLEAR_VAL;
      if (b_we) mem[b_addr] <= b_wword;
      if (a_we) mem[a_addr] <= a_wword;
   end

   // Clear FSM state and address counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear FSM next state: sweep every address once, then return to idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_END) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage 1: array read, valid and collision flag ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_v1_q <= 1'b0;
         b_v1_q <= 1'b0;
         a_d1_q <= '0;
         b_d1_q <= '0;
         coll_q <= 1'b0;
      end else begin
         a_v1_q <= a_rv;
         b_v1_q <= b_rv;
         if (a_rv) a_d1_q <= a_rdata;
         if (b_rv) b_d1_q <= b_rdata;
         coll_q <= a_acc & b_acc & same_addr & (a_wr | b_wr);
      end
   end

   assign collision = coll_q;

   // ---- stage 2: optional output register ----
   if (OUT_REG != 0) begin : g_oreg
      logic [RAM_DATA_WIDTH-1:0] a_d2_q, b_d2_q;
      logic                      a_v2_q, b_v2_q;

      // Second pipeline stage; data holds whenever no valid result arrives.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            a_v2_q <= 1'b0;
            b_v2_q <= 1'b0;
            a_d2_q <= '0;
            b_d2_q <= '0;
         end else begin
            a_v2_q <= a_v1_q;
            b_v2_q <= b_v1_q;
            if (a_v1_q) a_d2_q <= a_d1_q;
            if (b_v1_q) b_d2_q <= b_d1_q;
         end
      end

      assign a_data_out = a_d2_q;
      assign a_valid    = a_v2_q;
      assign b_data_out = b_d2_q;
      assign b_valid    = b_v2_q;
   end else begin : g_noreg
      assign a_data_out = a_d1_q;
      assign a_valid    = a_v1_q;
      assign b_data_out = b_d1_q;
      assign b_valid    = b_v1_q;
   end

endmodule

// File: tb/tb_bram_sync_dp_be.sv
// Bench for bram_sync_dp_be: three instances share one stimulus stream
// (read-first/no-oreg, write-first/oreg, no-change/no-oreg). A behavioural
// model predicts every output each cycle; directed literals pin the model.
module tb_bram_sync_dp_be;

   localparam logic [31:0] CLR = 32'h0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_en, a_wr, b_en, b_wr, clr_start;
   logic [3:0]  a_be, b_be, a_addr, b_addr;
   logic [31:0] a_data_in, b_data_in;

   logic [31:0] ado [3];
   logic [31:0] bdo [3];
   logic        av [3];
   logic        bv [3];
   logic        busy [3];
   logic        coll [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_sync_dp_be #(.RD_MODE(0), .OUT_REG(0), .CLEAR_VAL(CLR)) u0 (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data_in(a_data_in),
      .a_data_out(ado[0]), .a_valid(av[0]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data_in(b_data_in),
      .b_data_out(bdo[0]), .b_valid(bv[0]),
      .clr_start(clr_start), .busy(busy[0]), .collision(coll[0]));

   bram_sync_dp_be #(.RD_MODE(1), .OUT_REG(1), .CLEAR_VAL(CLR)) u1 (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data_in(a_data_in),
      .a_data_out(ado[1]), .a_valid(av[1]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data_in(b_data_in),
      .b_data_out(bdo[1]), .b_valid(bv[1]),
      .clr_start(clr_start), .busy(busy[1]), .collision(coll[1]));

   bram_sync_dp_be #(.RD_MODE(2), .OUT_REG(0), .CLEAR_VAL(CLR)) u2 (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data_in(a_data_in),
      .a_data_out(ado[2]), .a_valid(av[2]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data_in(b_data_in),
      .b_data_out(bdo[2]), .b_valid(bv[2]),
      .clr_start(clr_start), .busy(busy[2]), .collision(coll[2]));

   function automatic int mode_of(int k);
      return k;
   endfunction

   function automatic int lat2(int k);
      return (k == 1) ? 1 : 0;
   endfunction

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [16];
   int          clr_left;
   logic        e_busy, e_coll;
   logic [31:0] e_ado [3];
   logic [31:0] e_bdo [3];
   logic        e_av [3];
   logic        e_bv [3];
   logic        p_av [3];
   logic        p_bv [3];
   logic [31:0] p_ad [3];
   logic [31:0] p_bd [3];

   task automatic model_reset();
      clr_left = 0;
      e_busy   = 1'b0;
      e_coll   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e_ado[k] = '0; e_bdo[k] = '0; e_av[k] = 1'b0; e_bv[k] = 1'b0;
         p_av[k]  = 1'b0; p_bv[k] = 1'b0; p_ad[k] = '0; p_bd[k] = '0;
      end
   endtask

   task automatic model_step();
      logic        was_busy, acc_a, acc_b, rv, dv;
      logic [31:0] old_a, old_b, rd, dd;
      was_busy = (clr_left > 0);
      acc_a    = a_en && !was_busy;
      acc_b    = b_en && !was_busy;
      old_a    = m_mem[a_addr];
      old_b    = m_mem[b_addr];
      if (was_busy) begin
         m_mem[16 - clr_left] = CLR;
         clr_left--;
      end else if (clr_start) begin
         clr_left = 16;
      end
      // B lanes first, then A lanes, so A wins on shared lanes
      for (int i = 0; i < 4; i++) begin
         if (acc_b && b_wr && b_be[i]) m_mem[b_addr][8*i +: 8] = b_data_in[8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
         if (acc_a && a_wr && a_be[i]) m_mem[a_addr][8*i +: 8] = a_data_in[8*i +: 8];
      end
      e_coll = acc_a && acc_b && (a_addr == b_addr) && (a_wr || b_wr);
      e_busy = (clr_left > 0);
      for (int k = 0; k < 3; k++) begin
         // port A
         rv = acc_a && !(a_wr && mode_of(k) == 2);
         rd = (a_wr && mode_of(k) == 1) ? m_mem[a_addr] : old_a;
         if (lat2(k) != 0) begin
            dv = p_av[k]; dd = p_ad[k]; p_av[k] = rv; p_ad[k] = rd;
         end else begin
            dv = rv; dd = rd;
         end
         e_av[k] = dv;
         if (dv) e_ado[k] = dd;
         // port B
         rv = acc_b && !(b_wr && mode_of(k) == 2);
         rd = (b_wr && mode_of(k) == 1) ? m_mem[b_addr] : old_b;
         if (lat2(k) != 0) begin
            dv = p_bv[k]; dd = p_bd[k]; p_bv[k] = rv; p_bd[k] = rd;
         end else begin
            dv = rv; dd = rd;
         end
         e_bv[k] = dv;
         if (dv) e_bdo[k] = dd;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else      model_step();
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.a_data_out", k), ado[k], e_ado[k]);
            chk($sformatf("u%0d.a_valid", k),    32'(av[k]), 32'(e_av[k]));
            chk($sformatf("u%0d.b_data_out", k), bdo[k], e_bdo[k]);
            chk($sformatf("u%0d.b_valid", k),    32'(bv[k]), 32'(e_bv[k]));
            chk($sformatf("u%0d.busy", k),       32'(busy[k]), 32'(e_busy));
            chk($sformatf("u%0d.collision", k),  32'(coll[k]), 32'(e_coll));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_a(input logic en, input logic wr, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] d);
      a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_data_in = d;
   endtask

   task automatic set_b(input logic en, input logic wr, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] d);
      b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_data_in = d;
   endtask

   task automatic idle();
      set_a(0, 0, 4'h0, 4'h0, 32'h0);
      set_b(0, 0, 4'h0, 4'h0, 32'h0);
      clr_start = 1'b0;
   endtask

   initial begin
      int n;
      idle();

      // reset held with random inputs
      for (int c = 0; c < 6; c++) begin
         set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               4'($urandom), $urandom);
         set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               4'($urandom), $urandom);
         clr_start = 1'($urandom_range(0, 1));
         tick();
      end
      chk("rst_a_data_out", ado[0], 32'h0);
      chk("rst_b_valid", 32'(bv[1]), 32'h0);
      chk("rst_busy", 32'(busy[0]), 32'h0);
      idle();
      #2 rst = 1'b1;
      tick();

      // bring the array to a known state with the clear engine
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      chk("init_busy_rise", 32'(busy[0]), 32'h1);
      n = 1;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (busy[0]) n++;
         else break;
      end
      chk("init_busy_len", n, 16);

      // basic write then cross-port read
      set_a(1, 1, 4'hF, 4'd2, 32'h1234_5678);
      tick();
      chk("t1_a_readfirst_old", ado[0], CLR);
      chk("t1_a_nochange_valid", 32'(av[2]), 32'h0);
      idle();
      set_b(1, 0, 4'h0, 4'd2, 32'h0);
      tick();
      chk("t1_b_data", bdo[0], 32'h1234_5678);
      chk("t1_b_valid", 32'(bv[0]), 32'h1);
      chk("t1_oreg_b_not_yet", 32'(bv[1]), 32'h0);
      chk("t1_oreg_a_writefirst", ado[1], 32'h1234_5678);
      idle();
      tick();
      chk("t1_oreg_b_data", bdo[1], 32'h1234_5678);
      chk("t1_oreg_b_valid", 32'(bv[1]), 32'h1);

      // byte enables
      set_a(1, 1, 4'hF, 4'd5, 32'hAABB_CCDD);
      tick();
      set_a(1, 1, 4'b0101, 4'd5, 32'h1122_3344);
      tick();
      chk("t2_readfirst_old", ado[0], 32'hAABB_CCDD);
      set_a(1, 0, 4'h0, 4'd5, 32'h0);
      tick();
      chk("t2_merged", ado[0], 32'hAA22_CC44);
      chk("t2_oreg_writefirst", ado[1], 32'hAA22_CC44);
      set_a(1, 1, 4'h0, 4'd5, 32'hFFFF_FFFF);
      tick();
      set_a(1, 0, 4'h0, 4'd5, 32'h0);
      tick();
      chk("t2_be0_nowrite", ado[0], 32'hAA22_CC44);

      // read-during-write modes
      set_a(1, 1, 4'hF, 4'd1, 32'h0);
      tick();
      set_a(1, 1, 4'hF, 4'd1, 32'hFFFF_0000);
      tick();
      chk("t3_mode0_old", ado[0], 32'h0);
      chk("t3_mode0_valid", 32'(av[0]), 32'h1);
      chk("t3_mode2_valid", 32'(av[2]), 32'h0);
      chk("t3_mode2_hold", ado[2], 32'hAA22_CC44);
      set_a(1, 0, 4'h0, 4'd1, 32'h0);
      tick();
      chk("t3_mode1_new", ado[1], 32'hFFFF_0000);
      chk("t3_mem_mode0", ado[0], 32'hFFFF_0000);
      chk("t3_mem_mode2", ado[2], 32'hFFFF_0000);

      // cross-port collisions
      idle();
      set_a(1, 1, 4'hF, 4'd7, 32'h0);
      tick();
      set_a(1, 1, 4'b0011, 4'd7, 32'h1111_1111);
      set_b(1, 1, 4'b0110, 4'd7, 32'h2222_2222);
      tick();
      chk("t4_coll", 32'(coll[0]), 32'h1);
      chk("t4_coll_oreg", 32'(coll[1]), 32'h1);
      idle();
      tick();
      chk("t4_coll_pulse", 32'(coll[0]), 32'h0);
      chk("t4_oreg_bothwrite", bdo[1], 32'h0022_1111);
      set_a(1, 0, 4'h0, 4'd7, 32'h0);
      tick();
      chk("t4_merge", ado[0], 32'h0022_1111);
      set_a(1, 1, 4'hF, 4'd7, 32'h5555_5555);
      set_b(1, 0, 4'h0, 4'd7, 32'h0);
      tick();
      chk("t4_reader_old", bdo[0], 32'h0022_1111);
      chk("t4_coll_wr_rd", 32'(coll[0]), 32'h1);
      idle();
      tick();
      chk("t4_oreg_reader_old", bdo[1], 32'h0022_1111);
      set_a(1, 0, 4'h0, 4'd7, 32'h0);
      set_b(1, 0, 4'h0, 4'd7, 32'h0);
      tick();
      chk("t4_rdrd_no_coll", 32'(coll[0]), 32'h0);
      chk("t4_rdrd_a", ado[0], 32'h5555_5555);
      chk("t4_rdrd_b", bdo[0], 32'h5555_5555);

      // clear engine with accesses during busy
      for (int i = 0; i < 8; i++) begin
         set_a(1, 1, 4'hF, 4'(2*i),   32'hC0DE_0000 | 32'(2*i));
         set_b(1, 1, 4'hF, 4'(2*i+1), 32'hC0DE_0000 | 32'(2*i+1));
         tick();
      end
      idle();
      set_a(1, 0, 4'h0, 4'd3, 32'h0);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      chk("t5_busy_rise", 32'(busy[0]), 32'h1);
      chk("t5_inflight_read", ado[0], 32'hC0DE_0003);
      chk("t5_inflight_valid", 32'(av[0]), 32'h1);
      n = 1;
      set_a(1, 1, 4'hF, 4'd0, 32'hDEAD_BEEF);
      set_b(1, 0, 4'h0, 4'd3, 32'h0);
      for (int t = 0; t < 40; t++) begin
         clr_start = (t == 5);
         tick();
         if (busy[0]) n++;
         else break;
      end
      idle();
      chk("t5_busy_len", n, 16);
      for (int i = 0; i < 16; i++) begin
         set_a(1, 0, 4'h0, 4'(i), 32'h0);
         set_b(1, 0, 4'h0, 4'(15-i), 32'h0);
         tick();
         chk($sformatf("t5_cleared_a%0d", i), ado[0], CLR);
         chk($sformatf("t5_cleared_b%0d", 15-i), bdo[0], CLR);
      end
      idle();

      // reset in the middle of a clear
      for (int i = 0; i < 8; i++) begin
         set_a(1, 1, 4'hF, 4'(2*i),   32'h5A5A_0000 | 32'(2*i));
         set_b(1, 1, 4'hF, 4'(2*i+1), 32'h5A5A_0000 | 32'(2*i+1));
         tick();
      end
      idle();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (5) tick();
      #3 rst = 1'b0;
      #1;
      chk("t6_busy_abort", 32'(busy[0]), 32'h0);
      chk("t6_a_out_reset", ado[0], 32'h0);
      tick();
      #3 rst = 1'b1;
      tick();
      set_b(1, 0, 4'h0, 4'd9, 32'h0);
      tick();
      chk("t6_lat1_b", bdo[0], 32'h5A5A_0009);
      chk("t6_lat2_not_yet", 32'(bv[1]), 32'h0);
      idle();
      tick();
      chk("t6_lat2_b", bdo[1], 32'h5A5A_0009);
      chk("t6_lat2_valid", 32'(bv[1]), 32'h1);
      for (int i = 0; i < 16; i++) begin
         set_a(1, 0, 4'h0, 4'(i), 32'h0);
         tick();
         chk($sformatf("t6_contents_%0d", i), ado[0],
             (i < 5) ? CLR : (32'h5A5A_0000 | 32'(i)));
      end
      idle();
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
